// File: rtl/ibex_mem_arb_pkg.sv
// Shared types and defaults for the Ibex instruction/data memory arbiter.
package ibex_mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_I = 3'd1,
    WAIT_D = 3'd2,
    ERR_I  = 3'd3,
    ERR_D  = 3'd4
  } owner_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [31:0] MEM_BASE_DEFAULT  = 32'h0000_0000;
  localparam int unsigned MEM_BYTES_DEFAULT = 65536;

  // 33-bit offset so a window ending at the top of the address space still compares correctly
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] size);
    logic [32:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (offset < size);
  endfunction

endpackage

// File: rtl/ibex_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the instruction port, bit 1 the data port.
module rr_arb2 import ibex_mem_arb_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e last_q, last_d;

  // Pick a winner and remember it; on a tie the port not granted last wins
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == PORT_I) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end else begin
      gnt_o = 2'b00;
    end
    if (gnt_o[1]) begin
      last_d = PORT_D;
    end else if (gnt_o[0]) begin
      last_d = PORT_I;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= PORT_I;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Shares one single-port RAM between the Ibex instruction and data ports,
// one outstanding transaction at a time, with out-of-range error responses.
module ibex_mem_arbiter import ibex_mem_arb_pkg::*; #(
  parameter logic [31:0] MemBase  = MEM_BASE_DEFAULT,
  parameter int unsigned MemBytes = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        protocol_err_o
);

  owner_e      state_q, state_d;
  logic        protocol_err_q, protocol_err_d;
  logic        resp_done;
  logic        in_wait;
  logic        can_grant;
  logic [1:0]  gnt;
  logic [31:0] win_addr;
  logic        win_in_range;

  assign in_wait      = (state_q == WAIT_I) || (state_q == WAIT_D);
  assign resp_done    = in_wait ? mem_rvalid_i : ((state_q == ERR_I) || (state_q == ERR_D));
  assign can_grant    = reset && ((state_q == IDLE) || resp_done);
  assign win_addr     = gnt[1] ? data_addr_i : instr_addr_i;
  assign win_in_range = addr_in_range(win_addr, MemBase, 33'(MemBytes));

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en_i  (can_grant),
    .req_i ({data_req_i, instr_req_i}),
    .gnt_o (gnt)
  );

  // State and sticky error registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Next owner: a fresh grant overrides completion back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           state_d = IDLE;
      WAIT_I, WAIT_D: state_d = mem_rvalid_i ? IDLE : state_q;
      ERR_I, ERR_D:   state_d = IDLE;
      default:        state_d = IDLE;
    endcase
    if (gnt[1]) begin
      state_d = win_in_range ? WAIT_D : ERR_D;
    end else if (gnt[0]) begin
      state_d = win_in_range ? WAIT_I : ERR_I;
    end else begin
      state_d = state_d;
    end
    protocol_err_d = protocol_err_q | (mem_rvalid_i && !in_wait);
  end

  // Request muxing and response routing
  always_comb begin
    instr_gnt_o    = gnt[0];
    data_gnt_o     = gnt[1];
    mem_req_o      = (gnt != 2'b00) && win_in_range;
    if (gnt[1]) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = 32'h0000_0000;
    end
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = 32'h0000_0000;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    data_rdata_o   = 32'h0000_0000;
    if (reset) begin
      case (state_q)
        WAIT_I: begin
          instr_rvalid_o = mem_rvalid_i;
          instr_rdata_o  = mem_rvalid_i ? mem_rdata_i : 32'h0000_0000;
        end
        WAIT_D: begin
          data_rvalid_o = mem_rvalid_i;
          data_rdata_o  = mem_rvalid_i ? mem_rdata_i : 32'h0000_0000;
        end
        ERR_I: begin
          instr_rvalid_o = 1'b1;
          instr_err_o    = 1'b1;
        end
        ERR_D: begin
          data_rvalid_o = 1'b1;
          data_err_o    = 1'b1;
        end
        default: begin
          instr_rvalid_o = 1'b0;
          data_rvalid_o  = 1'b0;
        end
      endcase
    end else begin
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
    end
  end

  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Randomised and directed bench for ibex_mem_arbiter against a transaction-level model.
module tb_ibex_mem_arbiter;

  localparam int unsigned MEM_WORDS = 16384;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam longint      SIZE      = 65536;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_rvalid_i, protocol_err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  ibex_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle response, optionally held back to emulate a stall
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        ram_init, ram_hold, inj_rvalid;
  logic        ram_pend_q;
  logic [31:0] ram_data_q;

  function automatic logic [13:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[15:2];
  endfunction

  assign mem_rvalid_i = (ram_pend_q && !ram_hold) || inj_rvalid;
  assign mem_rdata_i  = (ram_pend_q && !ram_hold) ? ram_data_q : 32'h0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < MEM_WORDS; i++)
        mem[i] <= (i == 32'h40) ? 32'h0 : (32'hA5A5_0000 | (32'(i) << 2));
      ram_pend_q <= 1'b0;
    end else if (mem_req_o) begin
      ram_pend_q <= 1'b1;
      ram_data_q <= mem[widx(mem_addr_o)];
      if (mem_we_o)
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[widx(mem_addr_o)][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end else if (ram_pend_q && !ram_hold) begin
      ram_pend_q <= 1'b0;
    end
  end

  // Transaction-level model: one outstanding response and the last granted port
  logic        m_out_v = 1'b0, m_out_err = 1'b0, m_out_port = 1'b0, m_last = 1'b0, m_prot = 1'b0;
  logic [31:0] m_out_data = 32'h0;
  int          n_pass = 0, n_total = 0;

  logic [1:0]  s_gnt;
  logic        s_mreq, s_irv, s_ierr, s_drv, s_derr, s_prot;
  logic [31:0] s_ird, s_drd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    logic        rv_now, can, inr, rst_n_s, mrv_s;
    logic [1:0]  e_gnt;
    logic [3:0]  e_rsp;
    logic [31:0] e_ird, e_drd, waddr, rd_cap;
    #3;
    s_gnt  = {data_gnt_o, instr_gnt_o};
    s_mreq = mem_req_o;
    s_irv  = instr_rvalid_o; s_ierr = instr_err_o; s_ird = instr_rdata_o;
    s_drv  = data_rvalid_o;  s_derr = data_err_o;  s_drd = data_rdata_o;
    s_prot = protocol_err_o;
    rst_n_s = reset; mrv_s = mem_rvalid_i;
    e_gnt = 2'b00; e_rsp = 4'b0000; e_ird = 32'h0; e_drd = 32'h0;
    rv_now = 1'b0; inr = 1'b0; rd_cap = 32'h0;
    waddr = data_addr_i;
    if (rst_n_s) begin
      rv_now = m_out_v && (m_out_err || mrv_s);
      if (rv_now && m_out_port) begin
        e_rsp[1:0] = {1'b1, m_out_err};
        e_drd = m_out_err ? 32'h0 : m_out_data;
      end else if (rv_now) begin
        e_rsp[3:2] = {1'b1, m_out_err};
        e_ird = m_out_err ? 32'h0 : m_out_data;
      end
      can = !m_out_v || rv_now;
      if (can && instr_req_i && data_req_i) e_gnt = m_last ? 2'b01 : 2'b10;
      else if (can) e_gnt = {data_req_i, instr_req_i};
      waddr = e_gnt[1] ? data_addr_i : instr_addr_i;
      inr = (longint'(waddr) - longint'(BASE) >= 0) && (longint'(waddr) - longint'(BASE) < SIZE);
      if (inr) rd_cap = mem[widx(waddr)];
    end
    chk("gnt", 32'(s_gnt), 32'(e_gnt));
    chk("mem_req", 32'(s_mreq), 32'((e_gnt != 2'b00) && inr));
    if ((e_gnt != 2'b00) && inr) begin
      chk("mem_addr", mem_addr_o, waddr);
      chk("mem_we", 32'(mem_we_o), 32'(e_gnt[1] && data_we_i));
      chk("mem_be", 32'(mem_be_o), e_gnt[1] ? 32'(data_be_i) : 32'hF);
      if (e_gnt[1]) chk("mem_wdata", mem_wdata_o, data_wdata_i);
    end
    chk("rsp_flags", 32'({s_irv, s_ierr, s_drv, s_derr}), 32'(e_rsp));
    chk("instr_rdata", s_ird, e_ird);
    chk("data_rdata", s_drd, e_drd);
    chk("protocol_err", 32'(s_prot), 32'(m_prot));
    @(posedge clk);
    if (!rst_n_s) begin
      m_out_v = 1'b0; m_last = 1'b0; m_prot = 1'b0;
    end else begin
      if (mrv_s && !(m_out_v && !m_out_err)) m_prot = 1'b1;
      if (e_gnt != 2'b00) begin
        m_out_v = 1'b1; m_out_port = e_gnt[1]; m_out_err = !inr;
        m_out_data = rd_cap; m_last = e_gnt[1];
      end else if (rv_now) begin
        m_out_v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_reqs();
    instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_reqs();
    reset = 1'b0; tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0]  seq;
    logic [31:0] r;
    reset = 1'b0; ram_init = 1'b1; ram_hold = 1'b0; inj_rvalid = 1'b0;
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    @(posedge clk); #1;
    ram_init = 1'b0;
    tick();
    reset = 1'b1;

    // Back-to-back instruction fetches
    instr_req_i = 1'b1; instr_addr_i = 32'h80; tick();
    chk("fetch0_gnt", 32'(s_gnt), 32'h1);
    instr_addr_i = 32'h84; tick();
    chk("fetch0_data", s_ird, 32'hA5A5_0080);
    instr_addr_i = 32'h88; tick();
    chk("fetch1_data", s_ird, 32'hA5A5_0084);
    instr_req_i = 1'b0; tick();
    chk("fetch2_data", s_ird, 32'hA5A5_0088);

    // Continuous contention right after reset alternates D, I, D, I
    do_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h200;
    data_req_i = 1'b1; data_addr_i = 32'h300;
    seq = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      seq = {seq[5:0], s_gnt};
    end
    chk("rr_order", 32'(seq), 32'h99);
    idle_reqs(); tick();

    // Partial store then load of the same word
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h100; data_be_i = 4'b0011;
    data_wdata_i = 32'hDEAD_BEEF; tick();
    data_we_i = 1'b0; data_be_i = 4'hF; tick();
    chk("ram_word", mem[14'h40], 32'h0000_BEEF);
    idle_reqs(); tick();
    chk("load_data", s_drd, 32'h0000_BEEF);
    chk("load_err", 32'(s_derr), 32'h0);

    // First byte past the RAM
    data_req_i = 1'b1; data_addr_i = BASE + 32'(SIZE); tick();
    chk("oor_mem_req", 32'(s_mreq), 32'h0);
    idle_reqs(); tick();
    chk("oor_rsp", 32'({s_drv, s_derr}), 32'h3);
    chk("oor_rdata", s_drd, 32'h0);

    // Reset while a data response is in flight
    data_req_i = 1'b1; data_addr_i = 32'h104; tick();
    idle_reqs(); reset = 1'b0; tick();
    chk("rst_drop_rv", 32'(s_drv), 32'h0);
    reset = 1'b1; tick();
    chk("rst_drop_prot", 32'(s_prot), 32'h0);
    chk("rst_drop_rv2", 32'(s_drv), 32'h0);

    // Stalled RAM response blocks further grants
    instr_req_i = 1'b1; instr_addr_i = 32'h40; ram_hold = 1'b1; tick();
    instr_addr_i = 32'h44; data_req_i = 1'b1; data_addr_i = 32'h48;
    tick(); tick();
    chk("stall_no_gnt", 32'(s_gnt), 32'h0);
    ram_hold = 1'b0; tick();
    chk("stall_release", 32'(s_ird), 32'hA5A5_0040);
    idle_reqs(); tick(); tick();

    // Stray rvalid while idle is sticky until reset
    inj_rvalid = 1'b1; tick();
    inj_rvalid = 1'b0; tick();
    chk("stray_set", 32'(s_prot), 32'h1);
    tick();
    chk("stray_hold", 32'(s_prot), 32'h1);
    do_reset(); tick();
    chk("stray_clr", 32'(s_prot), 32'h0);

    // Stray rvalid during an error response
    instr_req_i = 1'b1; instr_addr_i = 32'hFFFF_FFFC; tick();
    idle_reqs(); inj_rvalid = 1'b1; tick();
    inj_rvalid = 1'b0; tick();
    do_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      instr_req_i = 1'($urandom_range(0, 1));
      data_req_i  = 1'($urandom_range(0, 1));
      data_we_i   = 1'($urandom_range(0, 1));
      data_be_i   = 4'($urandom_range(0, 15));
      data_wdata_i = $urandom();
      r = $urandom();
      case ($urandom_range(0, 15))
        0:       instr_addr_i = 32'h0001_0000 + {r[7:2], 2'b00};
        1:       instr_addr_i = 32'h0000_FFFC;
        default: instr_addr_i = {16'h0, r[15:2], 2'b00};
      endcase
      r = $urandom();
      case ($urandom_range(0, 15))
        0:       data_addr_i = 32'hFFFF_0000 | {r[15:2], 2'b00};
        1:       data_addr_i = 32'h0000_FFFC;
        default: data_addr_i = {16'h0, r[15:2], 2'b00};
      endcase
      ram_hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) reset = 1'b0;
      else reset = 1'b1;
      tick();
    end
    ram_hold = 1'b0; reset = 1'b1; idle_reqs(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 Parameter MemBase, default 32'h0000_0000: byte base address of the shared single-port RAM.
REQ-002 Parameter MemBytes, default 65536: RAM size in bytes (16384 x 32-bit words).
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 instr_req_i/instr_gnt_o/instr_rvalid_o/instr_err_o  in/out/out/out  1 each  core instruction-port handshake.
REQ-006 instr_addr_i  in  32  fetch byte address; instr_rdata_o  out  32  fetch data.
REQ-007 data_req_i/data_we_i  in  1 each  load/store request and write enable; data_gnt_o/data_rvalid_o/data_err_o  out  1 each.
REQ-008 data_be_i  in  4  byte enables; data_addr_i/data_wdata_i  in  32 each; data_rdata_o  out  32.
REQ-009 mem_req_o/mem_we_o  out  1 each; mem_be_o  out  4; mem_addr_o/mem_wdata_o  out  32 each  RAM request port.
REQ-010 mem_rvalid_i  in  1; mem_rdata_i  in  32  RAM response; the RAM returns rvalid exactly one cycle after an accepted req.
REQ-011 protocol_err_o  out  1  sticky flag, set on an unexpected mem_rvalid_i.

Function
REQ-012 Each cycle, at most one request SHALL be granted: the gnt is combinational in the same cycle as the req, and mem_req_o follows the winner.
REQ-013 A grant SHALL be allowed only when no response is outstanding, or when the outstanding response completes in this cycle, giving one transaction per cycle back-to-back.
REQ-014 If only one port requests, that port SHALL win; if both request, the winner SHALL be the port not granted most recently (2-way round-robin).
REQ-015 The mem_* outputs SHALL carry the winner's addr, be and wdata; for an instruction grant, mem_we_o=0 and mem_be_o=4'hF.
REQ-016 An address outside [MemBase, MemBase+MemBytes) SHALL be granted with mem_req_o=0, and the next cycle SHALL return rvalid=1, err=1, rdata=0 to the owner.
REQ-017 The owner FSM SHALL have states IDLE, WAIT_I, WAIT_D, ERR_I and ERR_D; a grant moves it to WAIT_x (ERR_x if out of range), and completion without a new grant returns it to IDLE.
REQ-018 In WAIT_x, mem_rvalid_i SHALL drive x_rvalid_o=1 with x_rdata_o=mem_rdata_i and err=0; the other port's rvalid SHALL stay 0.
REQ-019 mem_rvalid_i in IDLE or ERR_x SHALL be discarded and SHALL set protocol_err_o.
REQ-020 A missing mem_rvalid_i in WAIT_x SHALL hold the state, and no new grants SHALL be issued until it arrives.
REQ-021 A requester deasserting req before gnt SHALL have no side effect, and the round-robin pointer SHALL update only on a grant.
REQ-022 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.

Reset
REQ-023 While reset=0 at a clk edge: FSM=IDLE, round-robin pointer=last-granted-instr (data wins the first tie), protocol_err_o=0.
REQ-024 During reset, all gnt, rvalid, err and mem_req_o outputs SHALL be 0.
REQ-025 A response outstanding when reset asserts SHALL be dropped, and its late mem_rvalid_i SHALL NOT be forwarded.

Structure
REQ-026 Package ibex_mem_arb_pkg SHALL hold owner_e (IDLE/WAIT_I/WAIT_D/ERR_I/ERR_D), port_e (PORT_I/PORT_D) and the MemBase/MemBytes defaults.
REQ-027 One sub-module, rr_arb2 (2-way round-robin arbiter with pointer register), SHALL be instantiated; the FSM and muxing SHALL stay in ibex_mem_arbiter.

Verification
REQ-028 Instruction-only reads at 0x80, 0x84, 0x88 on consecutive cycles -> gnt each cycle, and instr_rvalid_o one cycle later with RAM data in order.
REQ-029 Both ports request continuously after reset -> grants alternate D, I, D, I, and no port waits more than 1 cycle.
REQ-030 Data store addr 0x100, be=4'b0011, wdata 0xDEADBEEF, then a load from 0x100 -> RAM shows 0x0000BEEF in its low half, and the load returns it with data_err_o=0.
REQ-031 Data load at MemBase+MemBytes -> mem_req_o=0, and the next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
REQ-032 Reset asserted in the cycle after a data grant, with the RAM still pulsing mem_rvalid_i -> no rvalid forwarded, FSM=IDLE, and protocol_err_o=0 after reset.
REQ-033 mem_rvalid_i forced high while IDLE -> protocol_err_o=1, held until reset.
